uart_tx_feeder: RTL and testbench

- Byte-buffering front end that sits directly upstream of the UART transmitter in the hello_uart_echo path.
- Accepts bytes from the echo/control logic over a valid/ready interface and stores them in a synchronous FIFO.
- Launches one byte at a time into the transmitter using its start/data/busy interface.
- Decouples bursty producers from the slow serial line; drops nothing (backpressure only).

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_feeder_if.sv | 22 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_tx_feeder.sv | 78 +++++++
 tb/tb_uart_tx_feeder.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, feeder FSM states, baud divisor helper.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } feeder_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer byte handshake plus transmitter start/data/busy handshake.
interface uart_tx_feeder_if;
    import uart_pkg::*;

    logic                   in_valid;
    logic [UART_DATA_W-1:0] in_data;
    logic                   in_ready;
    logic                   tx_start;
    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_busy;

    modport slave (
        input  in_valid, in_data, tx_busy,
        output in_ready, tx_start, tx_data
    );

    modport master (
        output in_valid, in_data, tx_busy,
        input  in_ready, tx_start, tx_data
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes at full and pops at empty are ignored.
module sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and launches them one at a time into the UART transmitter.
// Byte into an idle, empty feeder reaches tx_start two cycles later; in_ready drops only at full.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_feeder_if.slave  bus,
    output logic [CNT_W-1:0] fifo_count,
    output logic             idle
);

    feeder_state_t          state_q;
    feeder_state_t          state_d;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_rdata;
    logic                   tx_start_q;
    logic [UART_DATA_W-1:0] tx_data_q;

    // Ready comes from the registered count, so a same-cycle pop never frees a slot early.
    assign bus.in_ready = !fifo_full;
    assign push         = bus.in_valid && !fifo_full;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (bus.in_data),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !bus.tx_busy) begin
                    pop     = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH:    state_d = WAIT_BUSY;
            WAIT_BUSY: if (bus.tx_busy)  state_d = WAIT_DONE;
            WAIT_DONE: if (!bus.tx_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= pop;
            if (pop) tx_data_q <= fifo_rdata;
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign idle         = fifo_empty && (state_q == IDLE) && !bus.tx_busy;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized scoreboard bench: behavioural UART line model, decoded bytes checked against push order.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    localparam int DEPTH      = 4;
    localparam int CNT_W      = $clog2(DEPTH + 1);
    localparam int CPB        = clks_per_bit(4, 1);
    localparam int FRAME_BITS = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] fifo_count;
    logic             idle;

    uart_tx_feeder_if bus();

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .fifo_count (fifo_count),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Transmitter model: busy rises the cycle after tx_start, frame is start + 8 data LSB first + stop.
    logic       line;
    logic [9:0] shreg;
    int         tick, bitn;
    always @(posedge clk) begin
        if (!rst_n) begin
            bus.tx_busy <= 1'b0;
            line        <= 1'b1;
            tick        <= 0;
            bitn        <= 0;
        end else if (!bus.tx_busy) begin
            if (bus.tx_start) begin
                bus.tx_busy <= 1'b1;
                shreg       <= {1'b1, bus.tx_data, 1'b0};
                line        <= 1'b0;
                tick        <= 0;
                bitn        <= 0;
            end
        end else if (tick == CPB - 1) begin
            tick <= 0;
            if (bitn == FRAME_BITS - 1) begin
                bus.tx_busy <= 1'b0;
            end else begin
                bitn <= bitn + 1;
                line <= shreg[bitn+1];
            end
        end else begin
            tick <= tick + 1;
        end
    end

    logic [7:0] exp_start[$];
    logic [7:0] exp_line[$];
    int         max_count = 0;
    bit         ready_low_seen = 0;
    int         full_pops = 0;

    // Monitor: launch checks and serial line decoding against the scoreboard.
    initial begin
        bit         prev_start = 0;
        int         prev_count = 0;
        bit         dec_active = 0;
        int         dec_cnt = 0;
        logic [7:0] dec_byte = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dec_active = 0;
                prev_start = 0;
                prev_count = 0;
                continue;
            end
            if (bus.tx_start) begin
                check_eq("start_while_busy", bus.tx_busy, 0);
                check_eq("start_pulse_width", prev_start, 0);
                if (exp_start.size() == 0) check_eq("unexpected_start", exp_start.size(), 1);
                else check_eq("tx_data", bus.tx_data, exp_start.pop_front());
                if (prev_count == DEPTH) begin
                    check_eq("pop_at_full_count", fifo_count, DEPTH - 1);
                    check_eq("pop_at_full_ready", bus.in_ready, 1);
                    full_pops++;
                end
            end
            if (int'(fifo_count) > max_count) max_count = fifo_count;
            if (!bus.in_ready) ready_low_seen = 1;

            if (!dec_active) begin
                if (line == 1'b0) begin
                    dec_active = 1;
                    dec_cnt    = 0;
                end
            end else begin
                dec_cnt++;
                if (dec_cnt % CPB == 0 && dec_cnt <= 8 * CPB) begin
                    dec_byte[dec_cnt/CPB-1] = line;
                end else if (dec_cnt == 9 * CPB) begin
                    check_eq("stop_bit", line, 1);
                    if (exp_line.size() == 0) check_eq("unexpected_frame", exp_line.size(), 1);
                    else check_eq("line_byte", dec_byte, exp_line.pop_front());
                    dec_active = 0;
                end
            end
            prev_start = bus.tx_start;
            prev_count = fifo_count;
        end
    end

    // Stimulus always runs 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b, output int waits);
        bit acc;
        waits        = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        forever begin
            acc = bus.in_ready;
            step(1);
            if (acc) break;
            waits++;
            if (waits > 2000) begin
                check_eq("push_timeout", waits, 0);
                break;
            end
        end
        if (acc) begin
            exp_start.push_back(b);
            exp_line.push_back(b);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (!(idle && exp_line.size() == 0 && exp_start.size() == 0) && n < bound) begin
            step(1);
            n++;
        end
        check_eq("drain_idle", idle, 1);
    endtask

    initial begin
        int w;
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
        rst_n        = 1'b0;
        step(3);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_ready", bus.in_ready, 1);
        check_eq("rst_start", bus.tx_start, 0);
        check_eq("rst_data", bus.tx_data, 0);
        check_eq("rst_idle", idle, 1);
        rst_n = 1'b1;
        step(5);

        // Single byte: accepted at edge e, tx_start visible after edge e+1.
        push_byte(8'h55, w);
        check_eq("single_wait", w, 0);
        check_eq("latency_early", bus.tx_start, 0);
        step(1);
        check_eq("latency_start", bus.tx_start, 1);
        check_eq("latency_data", bus.tx_data, 8'h55);
        wait_drain(200);

        begin
            logic [7:0] burst [4] = '{8'hA3, 8'h01, 8'hFF, 8'h7E};
            for (int i = 0; i < 4; i++) begin
                push_byte(burst[i], w);
                check_eq("burst_ready", w, 0);
            end
        end
        wait_drain(400);

        // Overfill while the first frame is on the line.
        for (int i = 0; i < 6; i++) push_byte(8'($urandom), w);
        wait_drain(800);

        for (int i = 0; i < 10; i++) push_byte(8'(i), w);
        wait_drain(1200);

        for (int i = 0; i < 24; i++) begin
            step($urandom_range(0, 60));
            push_byte(8'($urandom), w);
        end
        wait_drain(2500);

        // Reset in the middle of a frame with three bytes still queued.
        for (int i = 0; i < 4; i++) push_byte(8'($urandom), w);
        begin
            int n = 0;
            while (!bus.tx_busy && n < 100) begin
                step(1);
                n++;
            end
            check_eq("midreset_busy", bus.tx_busy, 1);
        end
        step(8);
        check_eq("midreset_count_before", fifo_count, 3);
        rst_n = 1'b0;
        exp_start.delete();
        exp_line.delete();
        step(1);
        rst_n = 1'b1;
        check_eq("midreset_count", fifo_count, 0);
        check_eq("midreset_ready", bus.in_ready, 1);
        check_eq("midreset_start", bus.tx_start, 0);
        check_eq("midreset_line", line, 1);
        step(150);
        check_eq("post_reset_idle", idle, 1);

        check_eq("max_count", max_count, DEPTH);
        check_eq("ready_low_seen", ready_low_seen, 1);
        check_eq("full_pop_seen", full_pops > 0, 1);
        check_eq("leftover_expected", exp_line.size() + exp_start.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
